// File: rtl/picorv_loader_pkg.sv
// Definitions shared by the CPU-side loader and the USB-side bus slave:
// mode encodings, memory size, USB register map and the count-word layout.
package picorv_loader_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN   = 3'b001,
    MODE_LOAD  = 3'b010,
    MODE_RESET = 3'b100
  } mode_t;

  localparam int MEM_TOP = 32'h4000;
  localparam int CNT_W   = 15;

  localparam logic [7:0] USB_REG_STATE  = 8'h00;
  localparam logic [7:0] USB_REG_MEM    = 8'h01;
  localparam logic [7:0] USB_REG_SERIAL = 8'h02;

  typedef struct packed {
    logic [16:0]      rsvd;
    logic [CNT_W-1:0] byte_cnt;
  } count_word_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_CMD_WAIT,
    RD_BYTE_WAIT
  } rd_state_t;

  // Unknown command codes fall back to RESET so the core is never left running.
  function automatic mode_t decode_mode(input logic [2:0] code);
    case (code)
      3'b001:  return MODE_RUN;
      3'b010:  return MODE_LOAD;
      default: return MODE_RESET;
    endcase
  endfunction

  function automatic logic [31:0] count_word(input logic [CNT_W-1:0] cnt);
    count_word_t w;
    w.rsvd     = '0;
    w.byte_cnt = cnt;
    return w;
  endfunction

endpackage

// File: rtl/picorv_loader_if.sv
// Bundle of FIFO, program-RAM and core-side signals seen by the loader.
interface picorv_loader_if
  import picorv_loader_pkg::*;
#(
  parameter int ADDR_W = 12
);
  logic              state_fifo_empty;
  logic [7:0]        state_fifo_out;
  logic              state_fifo_rd_en;
  logic              state_fifo_rd_rst_busy;
  logic              mem_fifo_empty;
  logic [7:0]        mem_fifo_out;
  logic              mem_fifo_rd_en;
  logic              mem_fifo_rd_rst_busy;
  logic              serial_fifo_full;
  logic              serial_fifo_wr_rst_busy;
  logic [31:0]       serial_fifo_in;
  logic              serial_fifo_wr_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic              cpu_resetn;
  logic              cpu_ser_valid;
  logic [31:0]       cpu_ser_data;
  logic              cpu_ser_ready;
  logic [MODE_W-1:0] mode;

  modport master (
    input  state_fifo_empty, state_fifo_out, state_fifo_rd_rst_busy,
    input  mem_fifo_empty, mem_fifo_out, mem_fifo_rd_rst_busy,
    input  serial_fifo_full, serial_fifo_wr_rst_busy,
    input  cpu_ser_valid, cpu_ser_data,
    output state_fifo_rd_en, mem_fifo_rd_en,
    output serial_fifo_in, serial_fifo_wr_en,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output cpu_resetn, cpu_ser_ready, mode
  );

  modport slave (
    output state_fifo_empty, state_fifo_out, state_fifo_rd_rst_busy,
    output mem_fifo_empty, mem_fifo_out, mem_fifo_rd_rst_busy,
    output serial_fifo_full, serial_fifo_wr_rst_busy,
    output cpu_ser_valid, cpu_ser_data,
    input  state_fifo_rd_en, mem_fifo_rd_en,
    input  serial_fifo_in, serial_fifo_wr_en,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  cpu_resetn, cpu_ser_ready, mode
  );

endinterface

// File: rtl/picorv_loader_word_packer.sv
// Little-endian byte-to-word packer; exposes the completed word on the 4th
// byte and a zero-filled copy of a partial word for flushing.
module picorv_loader_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word_data,
  output logic [31:0] flush_data,
  output logic        partial
);

  logic [1:0] idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= '0;
    end else if (clear) begin
      idx_reg <= '0;
    end else if (push) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_lane
      logic [7:0] lane_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg <= '0;
        end else if (clear) begin
          lane_reg <= '0;
        end else if (push && idx_reg == 2'(gi)) begin
          lane_reg <= byte_in;
        end
      end

      // Stale lanes from an earlier word are masked rather than cleared.
      assign word_data[8*gi +: 8]  = (idx_reg == 2'(gi)) ? byte_in : lane_reg;
      assign flush_data[8*gi +: 8] = (2'(gi) < idx_reg) ? lane_reg : 8'h00;
    end
  endgenerate

  assign word_done = push && (idx_reg == 2'd3);
  assign partial   = (idx_reg != 2'd0);

endmodule

// File: rtl/picorv_loader.sv
// CPU-side consumer of the host command path: mode control, program-RAM
// loading from the byte FIFO, and count/serial-word return.
module picorv_loader
  import picorv_loader_pkg::*;
#(
  parameter int MEM_BYTES = 16384,
  parameter int ADDR_W    = 12
) (
  input  logic clk,
  input  logic resetn,
  picorv_loader_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_BYTES);

  rd_state_t         state_reg, state_next;
  mode_t             mode_reg, new_mode;
  logic [CNT_W-1:0]  byte_cnt_reg, count_val_reg;
  logic              count_pending_reg;
  logic              mem_wr_en_reg;
  logic [ADDR_W-1:0] mem_wr_addr_reg;
  logic [31:0]       mem_wr_data_reg;

  logic cmd_rd, byte_rd, cmd_take, byte_take;
  logic load_entry, load_exit, flush_wr, byte_accept;
  logic ser_space, push_cnt, ser_hs;
  logic pk_word_done, pk_partial;
  logic [31:0] pk_word_data, pk_flush_data;
  logic unused_cmd_bits;

  assign unused_cmd_bits = ^bus.state_fifo_out[7:3];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= RD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Only one FIFO read in flight; commands win over memory bytes.
  always_comb begin
    state_next = state_reg;
    cmd_rd     = 1'b0;
    byte_rd    = 1'b0;
    case (state_reg)
      RD_IDLE: begin
        if (!bus.state_fifo_empty && !bus.state_fifo_rd_rst_busy) begin
          cmd_rd     = 1'b1;
          state_next = RD_CMD_WAIT;
        end else if ((mode_reg == MODE_LOAD || mode_reg == MODE_RESET) &&
                     !bus.mem_fifo_empty && !bus.mem_fifo_rd_rst_busy) begin
          byte_rd    = 1'b1;
          state_next = RD_BYTE_WAIT;
        end
      end
      default: state_next = RD_IDLE;
    endcase
  end

  assign cmd_take    = (state_reg == RD_CMD_WAIT);
  assign byte_take   = (state_reg == RD_BYTE_WAIT);
  assign new_mode    = decode_mode(bus.state_fifo_out[2:0]);
  assign load_entry  = cmd_take && (new_mode == MODE_LOAD);
  assign load_exit   = cmd_take && (mode_reg == MODE_LOAD) && (new_mode != MODE_LOAD);
  assign flush_wr    = load_exit && pk_partial;
  assign byte_accept = byte_take && (mode_reg == MODE_LOAD) && (byte_cnt_reg != CNT_MAX);

  picorv_loader_word_packer u_packer (
    .clk        (clk),
    .rst_n      (resetn),
    .clear      (load_entry || load_exit),
    .push       (byte_accept),
    .byte_in    (bus.mem_fifo_out),
    .word_done  (pk_word_done),
    .word_data  (pk_word_data),
    .flush_data (pk_flush_data),
    .partial    (pk_partial)
  );

  // Count becomes pending the cycle after its write, so it is latched after
  // byte_cnt has absorbed the byte that completed the word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_reg          <= MODE_RESET;
      byte_cnt_reg      <= '0;
      count_val_reg     <= '0;
      count_pending_reg <= 1'b0;
      mem_wr_en_reg     <= 1'b0;
      mem_wr_addr_reg   <= '0;
      mem_wr_data_reg   <= '0;
    end else begin
      mem_wr_en_reg <= pk_word_done || flush_wr;
      if (pk_word_done) begin
        mem_wr_addr_reg <= byte_cnt_reg[ADDR_W+1:2];
        mem_wr_data_reg <= pk_word_data;
      end else if (flush_wr) begin
        mem_wr_addr_reg <= byte_cnt_reg[ADDR_W+1:2];
        mem_wr_data_reg <= pk_flush_data;
      end

      if (load_entry) begin
        byte_cnt_reg <= '0;
      end else if (byte_accept) begin
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
      end

      if (cmd_take) begin
        mode_reg <= new_mode;
      end

      if (load_entry) begin
        count_pending_reg <= 1'b0;
      end else if (mem_wr_en_reg) begin
        count_pending_reg <= 1'b1;
        count_val_reg     <= byte_cnt_reg;
      end else if (push_cnt) begin
        count_pending_reg <= 1'b0;
      end
    end
  end

  assign ser_space = !bus.serial_fifo_full && !bus.serial_fifo_wr_rst_busy;
  assign push_cnt  = count_pending_reg && ser_space;
  assign ser_hs    = bus.cpu_ser_ready && bus.cpu_ser_valid;

  assign bus.state_fifo_rd_en  = cmd_rd;
  assign bus.mem_fifo_rd_en    = byte_rd;
  assign bus.cpu_ser_ready     = (mode_reg == MODE_RUN) && ser_space && !count_pending_reg;
  assign bus.serial_fifo_wr_en = push_cnt || ser_hs;
  assign bus.serial_fifo_in    = push_cnt ? count_word(count_val_reg) :
                                 (ser_hs ? bus.cpu_ser_data : 32'h0);
  assign bus.mem_wr_en         = mem_wr_en_reg;
  assign bus.mem_wr_addr       = mem_wr_addr_reg;
  assign bus.mem_wr_data       = mem_wr_data_reg;
  assign bus.cpu_resetn        = (mode_reg == MODE_RUN);
  assign bus.mode              = mode_reg;

endmodule

// File: tb/tb_picorv_loader.sv
// Directed bench for picorv_loader: FIFO models, write/push monitors, a
// command-decode vector table and hand-written multi-cycle sequences.
module tb_picorv_loader;
  import picorv_loader_pkg::*;

  localparam int ADDR_W    = 12;
  localparam int MEM_BYTES = 16384;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  picorv_loader_if #(.ADDR_W(ADDR_W)) bus ();

  picorv_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Standard-mode FIFO models: data appears the cycle after rd_en.
  logic [7:0] cmd_mem [0:255];
  logic [7:0] mem_mem [0:32767];
  int mem_pop_cyc [0:32767];
  int cmd_wp = 0, cmd_rp = 0, mem_wp = 0, mem_rp = 0;
  int cmd_pop_cyc = 0;
  int cyc = 0;

  assign bus.state_fifo_empty = (cmd_rp == cmd_wp);
  assign bus.mem_fifo_empty   = (mem_rp == mem_wp);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.state_fifo_rd_en && cmd_rp != cmd_wp) begin
      bus.state_fifo_out <= cmd_mem[cmd_rp];
      cmd_rp      <= cmd_rp + 1;
      cmd_pop_cyc <= cyc;
    end
    if (bus.mem_fifo_rd_en && mem_rp != mem_wp) begin
      bus.mem_fifo_out     <= mem_mem[mem_rp];
      mem_pop_cyc[mem_rp]  <= cyc;
      mem_rp               <= mem_rp + 1;
    end
  end

  logic [ADDR_W-1:0] wr_addr_log [0:8191];
  logic [31:0] wr_data_log [0:8191];
  int wr_cyc_log [0:8191];
  logic [31:0] ser_log [0:8191];
  int ser_cyc_log [0:8191];
  int wr_n = 0, ser_n = 0, rise_cyc = -1;
  logic prev_cpu_resetn = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_wr_en && wr_n < 8192) begin
      wr_addr_log[wr_n] <= bus.mem_wr_addr;
      wr_data_log[wr_n] <= bus.mem_wr_data;
      wr_cyc_log[wr_n]  <= cyc;
      wr_n <= wr_n + 1;
    end
    if (bus.serial_fifo_wr_en && ser_n < 8192) begin
      ser_log[ser_n]     <= bus.serial_fifo_in;
      ser_cyc_log[ser_n] <= cyc;
      ser_n <= ser_n + 1;
    end
    if (bus.cpu_resetn && !prev_cpu_resetn) rise_cyc <= cyc;
    prev_cpu_resetn <= bus.cpu_resetn;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] b);
    cmd_mem[cmd_wp] = b;
    cmd_wp = cmd_wp + 1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem_mem[mem_wp] = b;
    mem_wp = mem_wp + 1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while ((cmd_rp != cmd_wp || mem_rp != mem_wp) && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(cmd_rp == cmd_wp && mem_rp == mem_wp), 32'h1);
    tick(6);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [2:0] exp_mode;
    logic       exp_cpu_resetn;
  } cmd_vec_t;

  cmd_vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wr0, ser0, rp0, b0;
    bus.state_fifo_rd_rst_busy  = 1'b0;
    bus.mem_fifo_rd_rst_busy    = 1'b0;
    bus.serial_fifo_full        = 1'b0;
    bus.serial_fifo_wr_rst_busy = 1'b0;
    bus.cpu_ser_valid           = 1'b0;
    bus.cpu_ser_data            = 32'h0;

    vecs[0] = '{8'h01, 3'b001, 1'b1};
    vecs[1] = '{8'h02, 3'b010, 1'b0};
    vecs[2] = '{8'h04, 3'b100, 1'b0};
    vecs[3] = '{8'hF9, 3'b001, 1'b1};
    vecs[4] = '{8'h07, 3'b100, 1'b0};
    vecs[5] = '{8'h0A, 3'b010, 1'b0};
    vecs[6] = '{8'h00, 3'b100, 1'b0};

    tick(3);
    resetn = 1'b1;
    tick(2);
    check("rst_cpu_resetn", 32'(bus.cpu_resetn), 32'h0);
    check("rst_mode", 32'(bus.mode), 32'h4);
    check("rst_cmd_rd_en", 32'(bus.state_fifo_rd_en), 32'h0);
    check("rst_mem_rd_en", 32'(bus.mem_fifo_rd_en), 32'h0);
    check("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'h0);
    check("rst_ser_wr_en", 32'(bus.serial_fifo_wr_en), 32'h0);
    check("rst_ser_in", bus.serial_fifo_in, 32'h0);
    check("rst_ser_ready", 32'(bus.cpu_ser_ready), 32'h0);
    check("rst_wr_addr", 32'(bus.mem_wr_addr), 32'h0);
    check("rst_wr_data", bus.mem_wr_data, 32'h0);

    for (int i = 0; i < 7; i++) begin
      push_cmd(vecs[i].cmd);
      tick(4);
      $display("vec %0d: cmd 0x%02h -> mode %b cpu_resetn %b", i, vecs[i].cmd, bus.mode, bus.cpu_resetn);
      check($sformatf("vec%0d_mode", i), 32'(bus.mode), 32'(vecs[i].exp_mode));
      check($sformatf("vec%0d_cpu_resetn", i), 32'(bus.cpu_resetn), 32'(vecs[i].exp_cpu_resetn));
    end
    check("vec_no_writes", 32'(wr_n), 32'h0);
    check("vec_no_pushes", 32'(ser_n), 32'h0);

    // LOAD, eight bytes
    wr0 = wr_n; ser0 = ser_n; b0 = mem_wp;
    push_cmd(8'h02);
    tick(4);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
    wait_drain(200, "load8_drain");
    $display("load8: %0d writes, %0d count pushes", wr_n - wr0, ser_n - ser0);
    check("load8_nwr", 32'(wr_n - wr0), 32'd2);
    check("load8_addr0", 32'(wr_addr_log[wr0]), 32'd0);
    check("load8_data0", wr_data_log[wr0], 32'h44332211);
    check("load8_addr1", 32'(wr_addr_log[wr0+1]), 32'd1);
    check("load8_data1", wr_data_log[wr0+1], 32'h88776655);
    check("load8_wr_lat0", 32'(wr_cyc_log[wr0] - mem_pop_cyc[b0+3]), 32'd2);
    check("load8_wr_lat1", 32'(wr_cyc_log[wr0+1] - mem_pop_cyc[b0+7]), 32'd2);
    check("load8_npush", 32'(ser_n - ser0), 32'd2);
    check("load8_cnt0", ser_log[ser0], 32'd4);
    check("load8_cnt1", ser_log[ser0+1], 32'd8);
    check("load8_push_lat", 32'(ser_cyc_log[ser0] - mem_pop_cyc[b0+3] >= 3), 32'h1);

    // Restart LOAD, three bytes, then RUN forces a flush
    push_cmd(8'h02);
    tick(4);
    wr0 = wr_n; ser0 = ser_n;
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    wait_drain(100, "flush_bytes_drain");
    push_cmd(8'h01);
    wait_drain(100, "flush_cmd_drain");
    $display("flush: %0d writes, data 0x%08h, count 0x%08h", wr_n - wr0, wr_data_log[wr0], ser_log[ser0]);
    check("flush_nwr", 32'(wr_n - wr0), 32'd1);
    check("flush_addr", 32'(wr_addr_log[wr0]), 32'd0);
    check("flush_data", wr_data_log[wr0], 32'h00CCBBAA);
    check("flush_npush", 32'(ser_n - ser0), 32'd1);
    check("flush_cnt", ser_log[ser0], 32'd3);
    check("flush_rise_lat", 32'(rise_cyc - cmd_pop_cyc), 32'd2);
    check("flush_same_cycle", 32'(wr_cyc_log[wr0] - rise_cyc), 32'd0);
    check("flush_mode", 32'(bus.mode), 32'h1);

    // RUN serial passthrough and backpressure
    bus.cpu_ser_data  = 32'hDEADBEEF;
    bus.cpu_ser_valid = 1'b1;
    #1;
    $display("run: ready %b wr_en %b data 0x%08h", bus.cpu_ser_ready, bus.serial_fifo_wr_en, bus.serial_fifo_in);
    check("run_ready", 32'(bus.cpu_ser_ready), 32'h1);
    check("run_wr_en", 32'(bus.serial_fifo_wr_en), 32'h1);
    check("run_data", bus.serial_fifo_in, 32'hDEADBEEF);
    bus.serial_fifo_full = 1'b1;
    #1;
    check("run_full_ready", 32'(bus.cpu_ser_ready), 32'h0);
    check("run_full_wr_en", 32'(bus.serial_fifo_wr_en), 32'h0);
    tick(1);
    bus.cpu_ser_valid    = 1'b0;
    bus.serial_fifo_full = 1'b0;

    // Bytes queued in RUN stay put; bad command returns to RESET and drains them
    rp0 = mem_rp; wr0 = wr_n;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    tick(10);
    check("run_mem_untouched", 32'(mem_rp - rp0), 32'd0);
    push_cmd(8'h07);
    wait_drain(100, "badcmd_drain");
    $display("badcmd: mode %b cpu_resetn %b writes %0d", bus.mode, bus.cpu_resetn, wr_n - wr0);
    check("badcmd_mode", 32'(bus.mode), 32'h4);
    check("badcmd_cpu_resetn", 32'(bus.cpu_resetn), 32'h0);
    check("badcmd_nwr", 32'(wr_n - wr0), 32'd0);

    // Saturation with the serial FIFO held full
    bus.serial_fifo_full = 1'b1;
    push_cmd(8'h02);
    tick(4);
    wr0 = wr_n; ser0 = ser_n;
    for (int k = 0; k < MEM_BYTES + 4; k++) push_byte(8'(k));
    wait_drain(40000, "sat_drain");
    $display("sat: %0d writes, last addr %0d data 0x%08h", wr_n - wr0, wr_addr_log[wr_n-1], wr_data_log[wr_n-1]);
    check("sat_nwr", 32'(wr_n - wr0), 32'd4096);
    check("sat_first_data", wr_data_log[wr0], 32'h03020100);
    check("sat_last_addr", 32'(wr_addr_log[wr_n-1]), 32'd4095);
    check("sat_last_data", wr_data_log[wr_n-1], 32'hFFFEFDFC);
    check("sat_no_push_full", 32'(ser_n - ser0), 32'd0);
    bus.serial_fifo_full = 1'b0;
    tick(10);
    $display("sat release: %0d pushes, value %0d", ser_n - ser0, ser_log[ser0]);
    check("sat_npush", 32'(ser_n - ser0), 32'd1);
    check("sat_cnt", ser_log[ser0], 32'd16384);

    // Asynchronous reset in the middle of a partial word
    push_cmd(8'h02);
    tick(4);
    push_byte(8'h5A); push_byte(8'hA5);
    wait_drain(100, "arst_drain");
    wr0 = wr_n; ser0 = ser_n;
    #2 resetn = 1'b0;
    #1;
    check("arst_mode", 32'(bus.mode), 32'h4);
    check("arst_wr_addr", 32'(bus.mem_wr_addr), 32'h0);
    check("arst_wr_data", bus.mem_wr_data, 32'h0);
    tick(2);
    resetn = 1'b1;
    tick(10);
    $display("arst: %0d writes, %0d pushes after reset", wr_n - wr0, ser_n - ser0);
    check("arst_nwr", 32'(wr_n - wr0), 32'd0);
    check("arst_npush", 32'(ser_n - ser0), 32'd0);
    check("arst_cpu_resetn", 32'(bus.cpu_resetn), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
